dc_nbank_dataarray: RTL and testbench

DC_NBANK_DATAARRAY -- requirements
Module: dc_nbank_dataarray

---
 rtl/dc_nbank_dataarray.sv | 170 +++++++++++++++++
 tb/tb_dc_nbank_dataarray.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dc_nbank_dataarray.sv
`default_nettype none
// ============================================================================
// Module   : dc_nbank_dataarray
// Purpose  : Word-interleaved, multi-bank data cache array. Each bank holds
//            SETS*WAYS entries of DATA_W data bits plus per-byte valid bits.
//            There is one read channel with retry, whose response comes one
//            cycle after acceptance and is held while the consumer stalls.
//            There is one write/invalidate channel that is always accepted.
//            A write wins any bank conflict with a read. An invalidate
//            clears the addressed set/way in every bank at once.
// Ports    : clk, reset (async, active-low)
//            rd_valid/rd_retry/rd_set/rd_way/rd_word    read request
//            wr_valid/wr_inval/wr_set/wr_way/wr_word/
//            wr_data/wr_mask                            write / invalidate
//            ack_valid/ack_retry/ack_data/ack_vbits     read response
//            conflict_cnt                               saturating conflict count
// Config   : define DC_NBANK_FWD_EN to let a read that collides with a plain
//            write to the identical set/way/word proceed. The read then
//            returns the stored bytes merged with the write bytes.
// Revision : 1.0 - initial release
// ============================================================================
module dc_nbank_dataarray #(
  parameter  int NBANKS = 8,
  parameter  int DATA_W = 32,
  parameter  int SETS   = 32,
  parameter  int WAYS   = 8,
  localparam int VB_W   = DATA_W / 8,
  localparam int BB     = $clog2(NBANKS),
  localparam int SB     = $clog2(SETS),
  localparam int WB     = $clog2(WAYS)
) (
  input  logic              clk,
  input  logic              reset,
  // read request
  input  logic              rd_valid,
  output logic              rd_retry,
  input  logic [SB-1:0]     rd_set,
  input  logic [WB-1:0]     rd_way,
  input  logic [BB-1:0]     rd_word,
  // write / invalidate
  input  logic              wr_valid,
  input  logic              wr_inval,
  input  logic [SB-1:0]     wr_set,
  input  logic [WB-1:0]     wr_way,
  input  logic [BB-1:0]     wr_word,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [VB_W-1:0]   wr_mask,
  // read response
  output logic              ack_valid,
  input  logic              ack_retry,
  output logic [DATA_W-1:0] ack_data,
  output logic [VB_W-1:0]   ack_vbits,
  output logic [15:0]       conflict_cnt
);

  localparam int C_ENTRIES = SETS * WAYS;
  localparam int C_IW      = SB + WB;

  // Storage: data is never reset; valid bits are.
  logic [DATA_W-1:0] r_data  [NBANKS][C_ENTRIES];
  logic [VB_W-1:0]   r_vbits [NBANKS][C_ENTRIES];

  logic              r_ack_valid;
  logic [DATA_W-1:0] r_ack_data;
  logic [VB_W-1:0]   r_ack_vbits;
  logic [15:0]       r_conflict_cnt;

  logic [C_IW-1:0]   w_rd_idx;
  logic [C_IW-1:0]   w_wr_idx;
  logic              w_hold;
  logic              w_fwd;
  logic              w_conflict;
  logic              w_rd_accept;
  logic [DATA_W-1:0] w_rd_data;
  logic [VB_W-1:0]   w_rd_vbits;

  assign w_rd_idx = {rd_set, rd_way};
  assign w_wr_idx = {wr_set, wr_way};

  // A stalled response blocks new reads so ack_data can stay stable.
  assign w_hold = r_ack_valid & ack_retry;

`ifdef DC_NBANK_FWD_EN
  assign w_fwd = rd_valid & wr_valid & ~wr_inval &
                 (w_rd_idx == w_wr_idx) & (rd_word == wr_word);
`else
  assign w_fwd = 1'b0;
`endif

  // An invalidate touches every bank, so it collides with any read.
  assign w_conflict  = rd_valid & wr_valid & (wr_inval | (rd_word == wr_word)) & ~w_fwd;
  assign rd_retry    = w_hold | w_conflict;
  assign w_rd_accept = rd_valid & ~rd_retry;

  // Read path. The merge only matters when the forwarding case is active.
  always_comb begin
    w_rd_data  = r_data[rd_word][w_rd_idx];
    w_rd_vbits = r_vbits[rd_word][w_rd_idx];
    if (w_fwd) begin
      for (int i = 0; i < VB_W; i++) begin
        if (wr_mask[i]) begin
          w_rd_data[8*i +: 8] = wr_data[8*i +: 8];
        end
      end
      w_rd_vbits = w_rd_vbits | wr_mask;
    end
  end

  // Data bytes: a masked byte write. Invalidates leave the data untouched.
  always_ff @(posedge clk) begin
    if (wr_valid && !wr_inval) begin
      for (int i = 0; i < VB_W; i++) begin
        if (wr_mask[i]) begin
          r_data[wr_word][w_wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  // Valid bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NBANKS; b++) begin
        for (int e = 0; e < C_ENTRIES; e++) begin
          r_vbits[b][e] <= '0;
        end
      end
    end else if (wr_valid) begin
      if (wr_inval) begin
        for (int b = 0; b < NBANKS; b++) begin
          r_vbits[b][w_wr_idx] <= '0;
        end
      end else begin
        r_vbits[wr_word][w_wr_idx] <= r_vbits[wr_word][w_wr_idx] | wr_mask;
      end
    end
  end

  // Response register: load on accept, hold while stalled, else drop valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ack_valid <= 1'b0;
      r_ack_data  <= '0;
      r_ack_vbits <= '0;
    end else if (w_rd_accept) begin
      r_ack_valid <= 1'b1;
      r_ack_data  <= w_rd_data;
      r_ack_vbits <= w_rd_vbits;
    end else if (!w_hold) begin
      r_ack_valid <= 1'b0;
    end
  end

  // Count only the retries caused by a bank conflict, not those caused by a
  // stalled response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && !w_hold && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign ack_valid    = r_ack_valid;
  assign ack_data     = r_ack_data;
  assign ack_vbits    = r_ack_vbits;
  assign conflict_cnt = r_conflict_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dc_nbank_dataarray.sv
`default_nettype none
// ============================================================================
// Module   : tb_dc_nbank_dataarray
// Purpose  : Scoreboard bench for dc_nbank_dataarray (default parameters).
//            A negedge reference process predicts rd_retry and conflict_cnt.
//            It pushes the expected response of every accepted read into a
//            queue. A monitor pops that queue and compares it against each
//            response the DUT presents.
// Config   : honours DC_NBANK_FWD_EN in the same way as the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dc_nbank_dataarray;

  localparam int NB  = 8;
  localparam int NS  = 32;
  localparam int NW  = 8;
  localparam int ENT = NS * NW;
`ifdef DC_NBANK_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd_valid = 1'b0, rd_retry;
  logic [4:0]  rd_set = '0;
  logic [2:0]  rd_way = '0, rd_word = '0;
  logic        wr_valid = 1'b0, wr_inval = 1'b0;
  logic [4:0]  wr_set = '0;
  logic [2:0]  wr_way = '0, wr_word = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_mask = '0;
  logic        ack_valid, ack_retry = 1'b0;
  logic [31:0] ack_data;
  logic [3:0]  ack_vbits;
  logic [15:0] conflict_cnt;

  dc_nbank_dataarray dut (
    .clk(clk), .reset(reset),
    .rd_valid(rd_valid), .rd_retry(rd_retry), .rd_set(rd_set), .rd_way(rd_way), .rd_word(rd_word),
    .wr_valid(wr_valid), .wr_inval(wr_inval), .wr_set(wr_set), .wr_way(wr_way), .wr_word(wr_word),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .ack_valid(ack_valid), .ack_retry(ack_retry), .ack_data(ack_data), .ack_vbits(ack_vbits),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Reference state: a plain picture of what every bank entry holds.
  logic [31:0] m_data [NB][ENT];
  logic [3:0]  m_vb   [NB][ENT];
  int unsigned m_cnt;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  v;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] v);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{v[i]}};
    return m;
  endfunction

  // Reference process. Inputs are stable mid-cycle; decide this cycle's
  // outcome, then apply the edge's effect to the model.
  always @(negedge clk) begin
    if (reset) begin : model
      bit   hold, fwd, conflict, acc;
      int   ridx, widx;
      exp_t e;
      ridx = {rd_set, rd_way};
      widx = {wr_set, wr_way};
      hold = (exp_q.size() != 0) && ack_retry;
      fwd  = FWD && rd_valid && wr_valid && !wr_inval &&
             (rd_set == wr_set) && (rd_way == wr_way) && (rd_word == wr_word);
      conflict = rd_valid && wr_valid && (wr_inval || (rd_word == wr_word)) && !fwd;
      chk("rd_retry", {31'd0, rd_retry}, {31'd0, hold || conflict});
      chk("conflict_cnt", {16'd0, conflict_cnt}, m_cnt);
      acc = rd_valid && !(hold || conflict);
      if (acc) begin
        e.d = m_data[rd_word][ridx];
        e.v = m_vb[rd_word][ridx];
        if (fwd) begin
          e.d = (e.d & ~bmask(wr_mask)) | (wr_data & bmask(wr_mask));
          e.v = e.v | wr_mask;
        end
        exp_q.push_back(e);
      end
      if (conflict && !hold && m_cnt < 32'hFFFF) m_cnt++;
      if (wr_valid) begin
        if (wr_inval) begin
          for (int b = 0; b < NB; b++) m_vb[b][widx] = 4'h0;
        end else begin
          for (int i = 0; i < 4; i++) begin
            if (wr_mask[i]) begin
              m_data[wr_word][widx][8*i +: 8] = wr_data[8*i +: 8];
              m_vb[wr_word][widx][i] = 1'b1;
            end
          end
        end
      end
    end
  end

  // Monitor: the response must appear exactly while an expectation is queued.
  always @(posedge clk) begin
    #2;
    if (reset) begin
      if (ack_valid) begin
        if (exp_q.size() == 0) begin
          chk("ack_spurious", {31'd0, ack_valid}, 32'd0);
        end else begin
          chk("ack_vbits", {28'd0, ack_vbits}, {28'd0, exp_q[0].v});
          chk("ack_data", ack_data & bmask(exp_q[0].v), exp_q[0].d & bmask(exp_q[0].v));
          if (!ack_retry) void'(exp_q.pop_front());
        end
      end else if (exp_q.size() != 0) begin
        chk("ack_missing", {31'd0, ack_valid}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drv(input logic rv, input logic [4:0] rs, input logic [2:0] rw, input logic [2:0] rwd,
                     input logic wv, input logic wi, input logic [4:0] ws, input logic [2:0] ww,
                     input logic [2:0] wwd, input logic [31:0] wd, input logic [3:0] wm, input logic ar);
    @(posedge clk); #1;
    rd_valid = rv; rd_set = rs; rd_way = rw; rd_word = rwd;
    wr_valid = wv; wr_inval = wi; wr_set = ws; wr_way = ww; wr_word = wwd;
    wr_data = wd; wr_mask = wm; ack_retry = ar;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rd_valid = 0; wr_valid = 0; wr_inval = 0; ack_retry = 0;
    reset = 1'b0;
    exp_q.delete();
    m_cnt = 0;
    for (int b = 0; b < NB; b++)
      for (int e = 0; e < ENT; e++) m_vb[b][e] = 4'h0;
    #1;
    chk("rst_ack_valid", {31'd0, ack_valid}, 32'd0);
    chk("rst_ack_data", ack_data, 32'd0);
    chk("rst_ack_vbits", {28'd0, ack_vbits}, 32'd0);
    chk("rst_rd_retry", {31'd0, rd_retry}, 32'd0);
    chk("rst_conflict_cnt", {16'd0, conflict_cnt}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    do_reset();
    // Read of a never-written entry: vbits 0, no conflicts.
    drv(1, 3, 2, 5, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    idle();
    // Full write, then read on the very next cycle.
    drv(0, 0, 0, 0, 1, 0, 3, 2, 5, 32'hDEADBEEF, 4'hF, 0);
    drv(1, 3, 2, 5, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    idle();
    // Partial overwrite, read, invalidate, read.
    drv(0, 0, 0, 0, 1, 0, 3, 2, 5, 32'h0000AAAA, 4'h3, 0);
    drv(1, 3, 2, 5, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    drv(0, 0, 0, 0, 1, 1, 3, 2, 0, 32'hFFFFFFFF, 4'hF, 0);
    drv(1, 3, 2, 5, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    idle();
    // Same-bank conflict, then different banks in parallel.
    drv(1, 3, 2, 5, 1, 0, 1, 0, 5, 32'h12345678, 4'hF, 0);
    drv(1, 3, 2, 4, 1, 0, 1, 0, 5, 32'h9ABCDEF0, 4'hF, 0);
    drv(1, 1, 0, 5, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    idle();
    // Response stalled for 3 cycles, with a same-bank write during the stall.
    drv(1, 1, 0, 5, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    drv(1, 3, 2, 5, 1, 0, 6, 0, 5, 32'h55AA55AA, 4'hF, 1);
    drv(1, 3, 2, 4, 0, 0, 0, 0, 0, 32'h0, 4'h0, 1);
    drv(1, 6, 0, 5, 0, 0, 0, 0, 0, 32'h0, 4'h0, 1);
    drv(1, 6, 0, 5, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    idle();
    // Identical-entry read and write (forwarded when the feature is built in).
    drv(0, 0, 0, 0, 1, 0, 7, 1, 2, 32'h11223344, 4'hF, 0);
    drv(1, 7, 1, 2, 1, 0, 7, 1, 2, 32'h000000FF, 4'h1, 0);
    drv(1, 7, 1, 2, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    idle();
    // Reset while a response is stalled, then a first read after reset.
    drv(1, 7, 1, 2, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 4'h0, 1);
    do_reset();
    drv(1, 7, 1, 2, 0, 0, 0, 0, 0, 32'h0, 4'h0, 0);
    idle();
    // Random traffic over a small address window so collisions are frequent.
    for (int n = 0; n < 3000; n++) begin
      drv(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 3)), 3'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) == 0), 5'($urandom_range(0, 3)),
          3'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom),
          4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 3));
    end
    idle();
    idle();
    // Drive the counter into saturation and keep pushing it.
    for (int n = 0; n < 65600; n++) begin
      drv(1, 0, 0, 0, 1, 0, 1, 0, 0, 32'h0, 4'h0, 0);
    end
    repeat (3) idle();
    chk("cnt_saturated", {16'd0, conflict_cnt}, 32'h0000FFFF);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
